// File: rtl/line_raster_pkg.sv
// Shared types and width helpers for the line rasteriser.
package line_raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam int COORD_W_DEF = 16;

  // The error term needs two extra bits over a coordinate: one for sign and
  // one because it spans dx + dy with both at full coordinate magnitude.
  function automatic int err_width(input int coord_w);
    return coord_w + 2;
  endfunction

endpackage

// File: rtl/line_raster_if.sv
// Command and pixel-stream signals between the rasteriser and its neighbours.
interface line_raster_if #(
  parameter int COORD_W = 16
) ();

  logic               CMD_VALID;
  logic               CMD_READY;
  logic [COORD_W-1:0] X0;
  logic [COORD_W-1:0] Y0;
  logic [COORD_W-1:0] X1;
  logic [COORD_W-1:0] Y1;
  logic [COORD_W-1:0] Xcoord;
  logic [COORD_W-1:0] Ycoord;
  logic               PIX_VALID;
  logic               PIX_READY;
  logic               BUSY;
  logic               DONE;

  modport master (
    output CMD_VALID, X0, Y0, X1, Y1, PIX_READY,
    input  CMD_READY, Xcoord, Ycoord, PIX_VALID, BUSY, DONE
  );

  modport slave (
    input  CMD_VALID, X0, Y0, X1, Y1, PIX_READY,
    output CMD_READY, Xcoord, Ycoord, PIX_VALID, BUSY, DONE
  );

endinterface

// File: rtl/line_raster_step.sv
// One combinational Bresenham step: next (x, y, err) from the current point.
module line_raster_step #(
  parameter int COORD_W = 16,
  parameter int ERR_W   = COORD_W + 2
) (
  input  logic [COORD_W-1:0]      i_x,
  input  logic [COORD_W-1:0]      i_y,
  input  logic signed [ERR_W-1:0] i_err,
  input  logic [COORD_W-1:0]      i_dx,
  input  logic signed [ERR_W-1:0] i_dy,
  input  logic                    i_sx_pos,
  input  logic                    i_sy_pos,
  output logic [COORD_W-1:0]      o_x,
  output logic [COORD_W-1:0]      o_y,
  output logic signed [ERR_W-1:0] o_err
);

  logic signed [ERR_W:0]   w_e2;
  logic signed [ERR_W:0]   w_dx_cmp;
  logic signed [ERR_W:0]   w_dy_cmp;
  logic signed [ERR_W-1:0] w_dx_err;
  logic                    w_step_x;
  logic                    w_step_y;

  // Both conditions are evaluated against the same e2 so a diagonal move
  // updates x, y and err together.
  always_comb begin
    w_e2     = {i_err, 1'b0};
    w_dx_cmp = {{(ERR_W + 1 - COORD_W){1'b0}}, i_dx};
    w_dy_cmp = {i_dy[ERR_W-1], i_dy};
    w_dx_err = {{(ERR_W - COORD_W){1'b0}}, i_dx};
    w_step_x = (w_e2 >= w_dy_cmp);
    w_step_y = (w_e2 <= w_dx_cmp);
    o_err    = i_err;
    o_x      = i_x;
    o_y      = i_y;
    if (w_step_x) begin
      o_err = o_err + i_dy;
      o_x   = i_sx_pos ? (i_x + COORD_W'(1)) : (i_x - COORD_W'(1));
    end
    if (w_step_y) begin
      o_err = o_err + w_dx_err;
      o_y   = i_sy_pos ? (i_y + COORD_W'(1)) : (i_y - COORD_W'(1));
    end
  end

endmodule

// File: rtl/line_raster.sv
// Bresenham line rasteriser: takes one endpoint pair, streams every pixel.
module line_raster
  import line_raster_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  line_raster_if.slave bus
);

  localparam int ERR_W = err_width(COORD_W);

  state_t                  r_state;
  logic [COORD_W-1:0]      r_x0, r_y0, r_x1, r_y1;
  logic [COORD_W-1:0]      r_x, r_y;
  logic [COORD_W-1:0]      r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sx_pos, r_sy_pos;
  logic                    r_pix_valid, r_busy, r_done;

  logic [COORD_W-1:0]      w_dx, w_dy_mag;
  logic signed [ERR_W-1:0] w_dy, w_err_init;
  logic [COORD_W-1:0]      w_x_nxt, w_y_nxt;
  logic signed [ERR_W-1:0] w_err_nxt;
  logic                    w_last;

  // Setup quantities derived from the latched endpoints.
  always_comb begin
    w_dx       = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    w_dy_mag   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    w_dy       = -$signed({{(ERR_W - COORD_W){1'b0}}, w_dy_mag});
    w_err_init = $signed({{(ERR_W - COORD_W){1'b0}}, w_dx}) + w_dy;
    w_last     = (r_x == r_x1) && (r_y == r_y1);
  end

  line_raster_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_pos (r_sx_pos),
    .i_sy_pos (r_sy_pos),
    .o_x      (w_x_nxt),
    .o_y      (w_y_nxt),
    .o_err    (w_err_nxt)
  );

  // Sequencer: accept command, one setup cycle, then one step per handshake.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= ST_IDLE;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_pos    <= 1'b0;
      r_sy_pos    <= 1'b0;
      r_pix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.CMD_VALID) begin
            r_x0    <= bus.X0;
            r_y0    <= bus.Y0;
            r_x1    <= bus.X1;
            r_y1    <= bus.Y1;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_dx        <= w_dx;
          r_dy        <= w_dy;
          r_err       <= w_err_init;
          r_sx_pos    <= (r_x0 < r_x1);
          r_sy_pos    <= (r_y0 < r_y1);
          r_x         <= r_x0;
          r_y         <= r_y0;
          r_pix_valid <= 1'b1;
          r_state     <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.PIX_READY) begin
            if (w_last) begin
              r_pix_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= ST_IDLE;
            end else begin
              r_x   <= w_x_nxt;
              r_y   <= w_y_nxt;
              r_err <= w_err_nxt;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.CMD_READY = (r_state == ST_IDLE);
  assign bus.Xcoord    = r_x;
  assign bus.Ycoord    = r_y;
  assign bus.PIX_VALID = r_pix_valid;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster; outputs sampled on the falling edge.
module tb_line_raster;

  logic ACLK;
  logic ARESETN;
  int   vectors;
  int   miscompares;

  line_raster_if #(.COORD_W(16)) bus ();

  line_raster #(.COORD_W(16)) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .bus     (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check the pixel presented in the current cycle, then advance one cycle.
  task automatic px(input int x, input int y);
    chk("pix_valid", {31'd0, bus.PIX_VALID}, 32'd1);
    chk("xcoord", {16'd0, bus.Xcoord}, x);
    chk("ycoord", {16'd0, bus.Ycoord}, y);
    @(negedge ACLK);
  endtask

  // Present a command for one cycle and check the setup cycle that follows.
  task automatic cmd(input int x0, input int y0, input int x1, input int y1);
    chk("cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    bus.CMD_VALID = 1'b1;
    bus.X0 = 16'(x0);
    bus.Y0 = 16'(y0);
    bus.X1 = 16'(x1);
    bus.Y1 = 16'(y1);
    @(negedge ACLK);
    bus.CMD_VALID = 1'b0;
    chk("setup_busy", {31'd0, bus.BUSY}, 32'd1);
    chk("setup_pix_valid", {31'd0, bus.PIX_VALID}, 32'd0);
    chk("setup_cmd_ready", {31'd0, bus.CMD_READY}, 32'd0);
    @(negedge ACLK);
  endtask

  task automatic done_chk();
    chk("done", {31'd0, bus.DONE}, 32'd1);
    chk("done_pix_valid", {31'd0, bus.PIX_VALID}, 32'd0);
    chk("done_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("done_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;
    vectors = 0;
    miscompares = 0;
    ARESETN = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.X0 = '0;
    bus.Y0 = '0;
    bus.X1 = '0;
    bus.Y1 = '0;
    bus.PIX_READY = 1'b1;

    @(negedge ACLK);
    chk("rst_pix_valid", {31'd0, bus.PIX_VALID}, 32'd0);
    chk("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("rst_done", {31'd0, bus.DONE}, 32'd0);
    chk("rst_x", {16'd0, bus.Xcoord}, 32'd0);
    chk("rst_y", {16'd0, bus.Ycoord}, 32'd0);
    chk("rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    ARESETN = 1'b1;
    @(negedge ACLK);

    // Horizontal line, followed back-to-back by a vertical descending line.
    cmd(0, 0, 5, 0);
    for (int i = 0; i <= 5; i++) px(i, 0);
    done_chk();
    cmd(3, 7, 3, 2);
    for (int i = 7; i >= 2; i--) px(3, i);
    done_chk();
    @(negedge ACLK);
    chk("done_pulse_low", {31'd0, bus.DONE}, 32'd0);

    // Shallow slope.
    cmd(0, 0, 4, 2);
    px(0, 0);
    px(1, 1);
    px(2, 1);
    px(3, 2);
    px(4, 2);
    done_chk();

    // Steep line towards decreasing x, with a command held during the run.
    cmd(6, 1, 4, 5);
    bus.CMD_VALID = 1'b1;
    bus.X0 = 16'd100;
    bus.Y0 = 16'd100;
    px(6, 1);
    px(5, 2);
    px(5, 3);
    px(4, 4);
    bus.CMD_VALID = 1'b0;
    px(4, 5);
    done_chk();
    @(negedge ACLK);
    chk("ignored_cmd_busy", {31'd0, bus.BUSY}, 32'd0);

    // Degenerate single pixel.
    cmd(9, 9, 9, 9);
    chk("degen_busy", {31'd0, bus.BUSY}, 32'd1);
    px(9, 9);
    done_chk();
    @(negedge ACLK);

    // Diagonal with random back-pressure.
    cmd(0, 0, 15, 15);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 400) begin
      chk("stall_pix_valid", {31'd0, bus.PIX_VALID}, 32'd1);
      chk("stall_x", {16'd0, bus.Xcoord}, idx);
      chk("stall_y", {16'd0, bus.Ycoord}, idx);
      rdy = 1'($urandom_range(0, 1));
      bus.PIX_READY = rdy;
      @(negedge ACLK);
      if (rdy) idx++;
      cyc++;
    end
    chk("stall_pixels_consumed", idx, 32'd16);
    bus.PIX_READY = 1'b1;
    done_chk();
    @(negedge ACLK);

    // Reset in the middle of a line.
    cmd(0, 0, 10, 0);
    px(0, 0);
    px(1, 0);
    chk("pre_rst_x", {16'd0, bus.Xcoord}, 32'd2);
    #2 ARESETN = 1'b0;
    #1;
    chk("mid_rst_pix_valid", {31'd0, bus.PIX_VALID}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.BUSY}, 32'd0);
    chk("mid_rst_x", {16'd0, bus.Xcoord}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, bus.CMD_READY}, 32'd1);
    @(negedge ACLK);
    chk("mid_rst_done", {31'd0, bus.DONE}, 32'd0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_done", {31'd0, bus.DONE}, 32'd0);
    cmd(1, 2, 3, 2);
    px(1, 2);
    px(2, 2);
    px(3, 2);
    done_chk();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/line_raster.md
# line_raster

Bresenham line rasteriser that sits directly upstream of the coordinate-to-address stage of the frame-buffer write path. It accepts one line command (two endpoints) through a valid/ready handshake. It then emits every pixel coordinate on the line, one per accepted handshake, on `Xcoord`/`Ycoord`. `PIX_VALID` connects to the downstream stage's `ENB`; `PIX_READY` lets the downstream stage stall the stream.

## Interface
Parameters:
- `COORD_W`, 16: width of every coordinate.

Ports:
- `ACLK` in 1: single clock. All state changes on the rising edge.
- `ARESETN` in 1: reset. **Asynchronous, active-low.**
- `CMD_VALID` in 1: command present.
- `CMD_READY` out 1: block can accept a command (high only in IDLE).
- `X0`, `Y0` in COORD_W each: start point, unsigned.
- `X1`, `Y1` in COORD_W each: end point, unsigned.
- `Xcoord`, `Ycoord` out COORD_W each: current pixel, registered.
- `PIX_VALID` out 1: `Xcoord`/`Ycoord` hold a valid pixel. Drives downstream `ENB`.
- `PIX_READY` in 1: downstream consumes the pixel this cycle.
- `BUSY` out 1: high in SETUP and RUN.
- `DONE` out 1: one-cycle pulse after the final pixel is consumed.

## Operation
- States: IDLE, SETUP, RUN.
- **IDLE:** `CMD_READY`=1. When `CMD_VALID` is high, latch the endpoints and go to SETUP.
- **SETUP** (exactly one cycle), compute:
  - `dx = |X1-X0|` and `dy = -|Y1-Y0|`
  - `sx = +1` if `X0<X1`, else `-1`; `sy` likewise from Y
  - `err = dx + dy`
  - `x = X0`, `y = Y0`
  - then go to RUN.
- **RUN:** `PIX_VALID`=1 and `Xcoord`/`Ycoord` = (`x`, `y`).
  - On `PIX_READY` with (`x`,`y`) == (`X1`,`Y1`): go to IDLE and assert `DONE` the next cycle.
  - On `PIX_READY` otherwise, one Bresenham step with `e2 = 2*err`:
    - if `e2 >= dy`: `err += dy`, `x += sx`
    - if `e2 <= dx`: `err += dx`, `y += sy`
    - When both conditions hold, both updates apply in the same cycle (diagonal step).
  - Without `PIX_READY`: all state, `Xcoord`, `Ycoord` and `PIX_VALID` hold unchanged.
- **Arithmetic widths:**
  - `dx` and `|dy|` are COORD_W unsigned.
  - `err` is signed COORD_W+2; `e2` is signed COORD_W+3. No overflow is possible.
  - Coordinate updates never leave the endpoint range, so no wrap occurs.
- **Pixel count** per line = max(`dx`, `|dy|`) + 1, including both endpoints.
- **Degenerate line** (`X0==X1` and `Y0==Y1`): exactly one pixel, then `DONE`.
- `CMD_VALID` while not in IDLE is ignored; the command is not lost, because `CMD_READY` is low.
- **`ARESETN` low at any time**, including mid-line:
  - state goes to IDLE immediately; the line is abandoned and no `DONE` is produced
  - reset values: `PIX_VALID`=0, `BUSY`=0, `DONE`=0, `Xcoord`=`Ycoord`=0, `CMD_READY`=1

## Timing
- Command accepted at edge N → SETUP in cycle N+1 → first pixel valid in cycle N+2.
- Throughput: one pixel per cycle while `PIX_READY` is held high.
- `DONE` is high in the cycle after the final handshake. In that same cycle the block is in IDLE with `CMD_READY`=1, so back-to-back commands are allowed. The gap between the last pixel of one line and the first pixel of the next is 2 cycles.
- `BUSY` and `PIX_VALID` are registered. `CMD_READY` is decoded from the state register only, with no combinational path from `CMD_VALID`.
- `PIX_VALID` must not depend combinationally on `PIX_READY`.

## Structure
- Package `line_raster_pkg`:
  - state enum (IDLE, SETUP, RUN)
  - `ERR_W = COORD_W+2` derivation
- Sub-module `line_raster_step`: purely combinational Bresenham step. Inputs `x`, `y`, `err`, `dx`, `dy`, `sx`, `sy`; outputs next `x`, `y`, `err`. The top level holds the FSM, handshake and registers.

## Test plan
- **Reset then (0,0)→(5,0):** pixels (0,0)…(5,0) in 6 consecutive cycles starting 2 cycles after accept; `DONE` one cycle after (5,0) is consumed.
- **(3,7)→(3,2), vertical descending:** 6 pixels with `y` = 7,6,5,4,3,2; `x` constant 3.
- **(0,0)→(4,2):** exactly (0,0),(1,0)? No — exactly (0,0),(1,1),(2,1),(3,2),(4,2)? Check against a golden Bresenham model; 5 pixels, ends at (4,2).
- **(9,9)→(9,9):** a single pixel (9,9), then `DONE`; `BUSY` is high for 2 cycles.
- **(0,0)→(15,15) with `PIX_READY` toggled randomly:** no pixel duplicated or skipped, and the held pixel stays stable while stalled; 16 pixels on the diagonal.
- **`ARESETN` low during the 3rd pixel of (0,0)→(10,0):** `PIX_VALID` drops asynchronously, no `DONE`; a new command is accepted after release with its first pixel 2 cycles after accept.
